// File: rtl/db_bank_if.sv
// Switch-bank bus: raw switch pins in, debounced levels and change ticks out.
// The debouncer uses the slave modport; whoever drives the pins uses master.
interface db_bank_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] sw;
    logic [NCH-1:0] db_level;
    logic [NCH-1:0] rise_tick;
    logic [NCH-1:0] fall_tick;
    logic           any_chg;

    modport master (
        output sw,
        input  db_level, rise_tick, fall_tick, any_chg
    );

    modport slave (
        input  sw,
        output db_level, rise_tick, fall_tick, any_chg
    );
endinterface

// File: rtl/db_bank.sv
// Multi-channel switch debouncer. Each channel has a synchroniser chain feeding
// a 4-state debounce FSM with its own down-counter.
module db_bank #(
    parameter int NCH         = 4,
    parameter int DB_CYCLES   = 2000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    db_bank_if.slave   bus
);
    localparam int             CW   = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  LOAD = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_e;

    logic [NCH-1:0] sync_q [SYNC_STAGES];
    logic [NCH-1:0] s;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic [CW-1:0]  cnt_d   [NCH];
    logic [NCH-1:0] level_q, level_d;
    logic [NCH-1:0] rise_q,  rise_d;
    logic [NCH-1:0] fall_q,  fall_d;
    logic           any_q,   any_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ZERO: begin
                    if (s[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = LOAD;
                    end
                end
                WAIT1: begin
                    if (!s[i]) begin
                        state_d[i] = ZERO;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end else begin
                        state_d[i] = ONE;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end
                end
                ONE: begin
                    if (!s[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = LOAD;
                    end
                end
                WAIT0: begin
                    if (s[i]) begin
                        state_d[i] = ONE;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CW'(1);
                    end else begin
                        state_d[i] = ZERO;
                        level_d[i] = 1'b0;
                        fall_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ZERO;
                    level_d[i] = 1'b0;
                end
            endcase
        end
        any_d = |(rise_d | fall_d);
    end

    // Counters sit in flops (not RAM), so they are cleared with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ZERO;
                cnt_q[i]   <= '0;
            end
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the synchroniser shift read the previous stage's old value.
            sync_q[0] <= bus.sw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
        end
    end

    assign bus.db_level  = level_q;
    assign bus.rise_tick = rise_q;
    assign bus.fall_tick = fall_q;
    assign bus.any_chg   = any_q;
endmodule

// File: tb/tb_db_bank.sv
// Directed bench for db_bank: expected output events are queued with their due
// cycle when stimulus is driven and compared every cycle against the DUT.
module tb_db_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    db_bank_if #(.NCH(4)) if_m ();
    db_bank_if #(.NCH(1)) if_f ();
    db_bank_if #(.NCH(1)) if_b ();

    db_bank #(.NCH(4), .DB_CYCLES(4), .SYNC_STAGES(2)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(if_m.slave));
    db_bank #(.NCH(1), .DB_CYCLES(1), .SYNC_STAGES(2)) u_fast (
        .clk(clk), .rst_n(rst_n), .bus(if_f.slave));
    db_bank #(.NCH(1), .DB_CYCLES(2000000), .SYNC_STAGES(2)) u_big (
        .clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    typedef struct {
        int         due;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } exp_t;

    exp_t       sb_m[$];
    exp_t       sb_f[$];
    logic [3:0] lvl_m = '0;
    logic [3:0] lvl_f = '0;
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;
    int         bounce[5] = '{1, 0, 1, 1, 0};

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input bit fast, input int lat, input logic [3:0] level,
                        input logic [3:0] rise, input logic [3:0] fall);
        exp_t e;
        e.due   = cyc + lat;
        e.level = level;
        e.rise  = rise;
        e.fall  = fall;
        e.any   = |(rise | fall);
        if (fast) sb_f.push_back(e);
        else      sb_m.push_back(e);
    endtask

    task automatic check_outputs();
        logic [12:0] exp;
        exp_t        e;
        exp = {lvl_m, 9'b0};
        if (sb_m.size() != 0 && sb_m[0].due == cyc) begin
            e     = sb_m.pop_front();
            lvl_m = e.level;
            exp   = {e.level, e.rise, e.fall, e.any};
        end
        check("main", {if_m.db_level, if_m.rise_tick, if_m.fall_tick, if_m.any_chg}, exp);

        exp = {lvl_f, 9'b0};
        if (sb_f.size() != 0 && sb_f[0].due == cyc) begin
            e     = sb_f.pop_front();
            lvl_f = e.level;
            exp   = {e.level, e.rise, e.fall, e.any};
        end
        check("fast", {3'b0, if_f.db_level, 3'b0, if_f.rise_tick, 3'b0, if_f.fall_tick,
                       if_f.any_chg}, exp);

        check("big", {3'b0, if_b.db_level, 3'b0, if_b.rise_tick, 3'b0, if_b.fall_tick,
                      if_b.any_chg}, 13'b0);
    endtask

    // Advance n rising edges, sampling all DUTs on each following falling edge.
    task automatic cycle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_outputs();
        end
    endtask

    initial begin
        if_m.sw = '0;
        if_f.sw = '0;
        if_b.sw = '0;
        cycle(3);
        #2 rst_n = 1'b1;
        cycle(2);
        if_b.sw = 1'b1;

        // Reset: bring ch1-3 high, then reset asynchronously while ch0 is mid-WAIT1.
        if_m.sw = 4'hE;
        push(1'b0, 7, 4'hE, 4'hE, 4'h0);
        cycle(10);
        if_m.sw = 4'hF;
        cycle(3);
        #2 rst_n = 1'b0;
        lvl_m = '0;
        #1 check("rst_async", {if_m.db_level, if_m.rise_tick, if_m.fall_tick, if_m.any_chg}, 13'b0);
        cycle(2);
        #2 rst_n = 1'b1;
        push(1'b0, 7, 4'hF, 4'hF, 4'h0);
        cycle(10);

        // Clean press and release on ch1.
        if_m.sw = 4'h0;
        push(1'b0, 7, 4'h0, 4'h0, 4'hF);
        cycle(10);
        if_m.sw = 4'h2;
        push(1'b0, 7, 4'h2, 4'h2, 4'h0);
        cycle(10);
        if_m.sw = 4'h0;
        push(1'b0, 7, 4'h0, 4'h0, 4'h2);
        cycle(10);

        // Three-cycle glitch on ch2, then a full-latency press proves no partial credit.
        if_m.sw = 4'h4;
        cycle(3);
        if_m.sw = 4'h0;
        cycle(10);
        if_m.sw = 4'h4;
        push(1'b0, 7, 4'h4, 4'h4, 4'h0);
        cycle(10);
        if_m.sw = 4'h0;
        push(1'b0, 7, 4'h0, 4'h0, 4'h4);
        cycle(10);

        // Bounce on ch0, single rise 7 edges after the last 0->1.
        foreach (bounce[k]) begin
            if_m.sw[0] = bounce[k][0];
            cycle(1);
        end
        if_m.sw[0] = 1'b1;
        push(1'b0, 7, 4'h1, 4'h1, 4'h0);
        cycle(10);

        // Independence: ch3 rises as ch0 falls.
        if_m.sw = 4'h8;
        push(1'b0, 7, 4'h8, 4'h8, 4'h1);
        cycle(10);

        // DB_CYCLES=1: 4-edge latency both ways, single-cycle glitch rejected.
        if_f.sw = 1'b1;
        push(1'b1, 4, 4'h1, 4'h1, 4'h0);
        cycle(6);
        if_f.sw = 1'b0;
        push(1'b1, 4, 4'h0, 4'h0, 4'h1);
        cycle(6);
        if_f.sw = 1'b1;
        cycle(1);
        if_f.sw = 1'b0;
        cycle(6);

        check("sb_drain", 13'(sb_m.size() + sb_f.size()), 13'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
